// File: rtl/operand_sweeper.sv
// Walks the full (in1,in2,in3,cin,x1,x2,x3) operand space over a valid/ready handshake.
// Define SWEEP_REPEAT_EN to wrap continuously instead of stopping after one pass.
module operand_sweeper #(
   parameter int OPW = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic                 i_out_ready,
   output logic                 o_out_valid,
   output logic [OPW-1:0]       o_in1,
   output logic [OPW-1:0]       o_in2,
   output logic [OPW-1:0]       o_in3,
   output logic                 o_cin,
   output logic                 o_x1,
   output logic                 o_x2,
   output logic                 o_x3,
   output logic [3*OPW+3:0]     o_idx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int IW = 3*OPW+4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_nextIdx;
   logic            r_valid;
   logic            r_busy;
   logic            r_done;
   logic            w_nextDone;
   logic            w_xfer;
   logic            w_last;

   assign w_xfer = (r_state == RUN) && i_out_ready;
   assign w_last = &r_idx;

   // Valid/busy/done are flops loaded from next-state so no output depends on out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_idx   <= w_nextIdx;
         r_valid <= (w_nextState == RUN);
         r_busy  <= (w_nextState == RUN);
         r_done  <= w_nextDone;
      end
   end

   // Abort wins over the end-of-sweep transition and freezes idx where it was.
   always_comb begin
      w_nextState = r_state;
      w_nextIdx   = r_idx;
      w_nextDone  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_nextState = RUN;
               w_nextIdx   = '0;
            end
         end
         RUN: begin
            if (i_abort) begin
               w_nextState = IDLE;
            end else if (w_xfer) begin
               if (w_last) begin
`ifdef SWEEP_REPEAT_EN
                  w_nextIdx   = '0;
                  w_nextDone  = 1'b1;
`else
                  w_nextState = DONE;
                  w_nextDone  = 1'b1;
`endif
               end else begin
                  w_nextIdx = r_idx + IW'(1);
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign o_out_valid = r_valid;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_idx       = r_idx;
   assign o_in1       = r_idx[OPW-1:0];
   assign o_in2       = r_idx[2*OPW-1:OPW];
   assign o_in3       = r_idx[3*OPW-1:2*OPW];
   assign o_cin       = r_idx[3*OPW];
   assign o_x1        = r_idx[3*OPW+1];
   assign o_x2        = r_idx[3*OPW+2];
   assign o_x3        = r_idx[3*OPW+3];

endmodule

// File: tb/tb_operand_sweeper.sv
// Self-checking bench for operand_sweeper: directed vector table plus multi-cycle sequences.
// Honours SWEEP_REPEAT_EN to expect wrap-around behaviour at the end of the sweep.
module tb_operand_sweeper;

   localparam int OPW = 4;
   localparam int IW  = 3*OPW+4;
   localparam int LAST = (1 << IW) - 1;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic            outReady;
   logic            outValid;
   logic [OPW-1:0]  in1;
   logic [OPW-1:0]  in2;
   logic [OPW-1:0]  in3;
   logic            cin;
   logic            x1;
   logic            x2;
   logic            x3;
   logic [IW-1:0]   idx;
   logic            busy;
   logic            done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          start;
      logic          abort;
      logic          ready;
      logic          expValid;
      logic          expBusy;
      logic          expDone;
      int            expIdx;
   } vec_t;

   vec_t vecs [12];

   operand_sweeper #(.OPW(OPW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (start),
      .i_abort     (abort),
      .i_out_ready (outReady),
      .o_out_valid (outValid),
      .o_in1       (in1),
      .o_in2       (in2),
      .o_in3       (in3),
      .o_cin       (cin),
      .o_x1        (x1),
      .o_x2        (x2),
      .o_x3        (x3),
      .o_idx       (idx),
      .o_busy      (busy),
      .o_done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic r);
      start    = s;
      abort    = a;
      outReady = r;
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Advances with out_ready=1 until the presented idx equals target; returns 0 on timeout.
   task automatic waitIdx(input int target, input int budget, output bit ok);
      int n;
      n  = 0;
      ok = 1'b1;
      while (int'(idx) != target) begin
         if (n >= budget) begin
            ok = 1'b0;
            break;
         end
         step();
         n++;
      end
   endtask

   task automatic checkOperands(input string tag, input int e);
      logic [IW-1:0] ev;
      ev = IW'(e);
      checkOutput({tag, " idx"}, int'(idx), e);
      checkOutput({tag, " in1"}, int'(in1), int'(ev[3:0]));
      checkOutput({tag, " in2"}, int'(in2), int'(ev[7:4]));
      checkOutput({tag, " in3"}, int'(in3), int'(ev[11:8]));
      checkOutput({tag, " ctl"}, int'({x3, x2, x1, cin}), int'(ev[15:12]));
   endtask

   initial begin
      bit ok;
      int expIdx;
      bit sweepOk;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};

      // Reset then idle for 10 cycles
      applyReset();
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("idle valid", int'(outValid), 0);
         checkOutput("idle busy", int'(busy), 0);
         checkOutput("idle done", int'(done), 0);
         checkOutput("idle idx", int'(idx), 0);
      end

      // Vector table
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].ready);
         step();
         checkOutput($sformatf("vec%0d valid", i), int'(outValid), int'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d done", i), int'(done), int'(vecs[i].expDone));
         checkOutput($sformatf("vec%0d idx", i), int'(idx), vecs[i].expIdx);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Backpressure at idx 5
      applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitIdx(5, 20, ok);
      checkOutput("reach idx5", int'(ok), 1);
      outReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOperands("stall", 5);
         checkOutput("stall valid", int'(outValid), 1);
      end
      outReady = 1'b1;
      step();
      checkOutput("after stall idx", int'(idx), 6);

      // Abort at idx 300
      waitIdx(300, 400, ok);
      checkOutput("reach idx300", int'(ok), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      checkOutput("abort valid", int'(outValid), 0);
      checkOutput("abort busy", int'(busy), 0);
      checkOutput("abort done", int'(done), 0);
      checkOutput("abort idx", int'(idx), 300);
      step();
      checkOutput("abort done later", int'(done), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("restart valid", int'(outValid), 1);
      checkOutput("restart idx", int'(idx), 0);

      // Reset mid-sweep at idx 1000
      waitIdx(1000, 1100, ok);
      checkOutput("reach idx1000", int'(ok), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst valid", int'(outValid), 0);
      checkOutput("rst busy", int'(busy), 0);
      checkOutput("rst done", int'(done), 0);
      checkOperands("rst", 0);
      step();
      checkOutput("rst held done", int'(done), 0);
      rst_n = 1'b1;
      step();

      // Full sweep with out_ready held high
      applyStimulus(1'b1, 1'b0, 1'b1);
      step();
      start = 1'b0;
      sweepOk = 1'b1;
      for (expIdx = 0; expIdx <= LAST; expIdx++) begin
         logic [IW-1:0] ev;
         ev = IW'(expIdx);
         checks++;
         if (outValid !== 1'b1 || done !== 1'b0 || int'(idx) != expIdx ||
             in1 !== ev[3:0] || x3 !== ev[15]) begin
            errors++;
            sweepOk = 1'b0;
            $display("[TB] FAIL sweep: got valid=%0b done=%0b idx=%0d in1=%0d x3=%0b, expected valid=1 done=0 idx=%0d in1=%0d x3=%0b",
                     outValid, done, idx, in1, x3, expIdx, ev[3:0], ev[15]);
            break;
         end
         step();
      end
      if (sweepOk) begin
         checkOutput("end done", int'(done), 1);
`ifdef SWEEP_REPEAT_EN
         checkOutput("wrap valid", int'(outValid), 1);
         checkOutput("wrap idx", int'(idx), 0);
         step();
         checkOutput("wrap done clear", int'(done), 0);
         checkOutput("wrap valid hold", int'(outValid), 1);
         checkOutput("wrap idx next", int'(idx), 1);
         abort = 1'b1;
         step();
         abort = 1'b0;
         checkOutput("wrap abort valid", int'(outValid), 0);
         checkOutput("wrap abort done", int'(done), 0);
`else
         checkOutput("end valid", int'(outValid), 0);
         checkOutput("end busy", int'(busy), 0);
         checkOutput("end idx", int'(idx), LAST);
         step();
         checkOutput("end done clear", int'(done), 0);
         checkOutput("end idle valid", int'(outValid), 0);
         start = 1'b1;
         step();
         start = 1'b0;
         checkOutput("new start valid", int'(outValid), 1);
         checkOutput("new start idx", int'(idx), 0);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_sweeper.md
# operand_sweeper

Upstream stimulus stage for the 4-bit arithmetic sub-modules: walks the full operand space (in1, in2, in3, cin, x1, x2, x3) in a fixed order and presents one tuple per accepted transfer over a valid/ready handshake. A start/abort FSM controls it, and a one-cycle done pulse marks the end of a sweep. It sits directly in front of the combinational adders/muxes and drives their operand and control inputs from registers.

## Interface
- OPW, 4, operand width of in1/in2/in3.
- IW, 3*OPW+4 (derived, localparam), sweep index width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate the sweep; sampled only in RUN.
- out_ready  input  1  downstream accepts the current tuple.
- out_valid  output  1  the tuple on the operand outputs is valid.
- in1, in2, in3  output  OPW  operand fields.
- cin, x1, x2, x3  output  1 each  carry and select fields.
- idx  output  IW  index of the tuple currently presented.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the last tuple is accepted.

## Operation
- Index mapping (registered, pure bit slicing of idx):
  - in1 = idx[OPW-1:0], in2 = idx[2OPW-1:OPW], in3 = idx[3OPW-1:2OPW].
  - cin = idx[3OPW], x1 = idx[3OPW+1], x2 = idx[3OPW+2], x3 = idx[3OPW+3].
- FSM states: IDLE, RUN, DONE.
- IDLE: out_valid=0, busy=0. When start=1, the next state is RUN and idx is cleared to 0.
- RUN: out_valid=1, busy=1. A transfer occurs when out_valid && out_ready.
  - Transfer with idx != 2^IW-1: idx increments by 1.
  - Transfer with idx == 2^IW-1: the next state is DONE. idx holds.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE.
- abort in RUN: the next state is IDLE and idx holds its value.
  - abort has priority over the end-of-sweep transition, so no done pulse is produced.
  - A transfer in the same cycle as abort is still a completed transfer from downstream's view.
- When out_valid=1 and out_ready=0, all operand outputs and idx remain stable.
- start is ignored in RUN and DONE. abort is ignored in IDLE and DONE.
- Reset asserted mid-sweep returns to IDLE immediately. No done pulse is produced.

## Timing
- Reset values: out_valid=0, busy=0, done=0, idx=0, and all operand fields 0.
- start is sampled at edge N. out_valid=1 with idx=0 is visible after edge N.
- With out_ready held at 1, the sweep makes one transfer per cycle and takes 2^IW cycles (65536 at OPW=4).
- The last transfer is at edge M. done=1 in cycle M+1, and the FSM is in IDLE from edge M+2.
- A new start can be accepted on the first cycle the FSM is in IDLE.
- All outputs are registered. There is no combinational path from out_ready to out_valid.

## Configuration
- SWEEP_REPEAT_EN defined:
  - A transfer at idx == 2^IW-1 wraps idx to 0 and stays in RUN.
  - done pulses for one cycle coincident with the wrap. out_valid stays high.
  - Only abort or reset ends the sweep, and the DONE state is unreachable.
- SWEEP_REPEAT_EN undefined: single-pass behaviour as described in Operation.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles and release with start=0. out_valid, busy, done and idx stay 0 for 10 cycles.
- Full sweep, OPW=4, out_ready=1: pulse start. The bench sees 65536 transfers with idx 0..65535 in order. in1=idx[3:0] and x3=idx[15] are checked on every transfer. done pulses once, on the cycle after idx=65535 is accepted.
- Backpressure: at idx=5, drop out_ready for 4 cycles. in1=5, in2=0, in3=0 and idx stay stable. After out_ready rises, the next accepted tuple has idx=6.
- Abort: pulse abort at idx=300. out_valid drops on the next cycle with idx held at 300, done stays 0, and a subsequent start restarts from idx=0.
- Reset mid-sweep: assert rst_n=0 at idx=1000. All outputs clear asynchronously with no done pulse.
- SWEEP_REPEAT_EN: run past idx=65535. The next tuple has idx=0 with a single done pulse, and out_valid is never deasserted.
